// File: rtl/io_map_pkg.sv
// Memory map, data widths and ack FSM state encoding for the bird I/O controller.
package io_map_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] BEGINMEM   = 16'h0000;
  localparam logic [ADDR_W-1:0] ENDMEM     = 16'h01ff;
  localparam logic [ADDR_W-1:0] KEYPAD     = 16'h0900;
  localparam logic [ADDR_W-1:0] KEYPAD_ST  = KEYPAD + 16'd1;
  localparam logic [ADDR_W-1:0] SEVENSEG   = 16'h0b00;
  localparam logic [ADDR_W-1:0] TIMER      = 16'h0c00;
  localparam logic [ADDR_W-1:0] TIMER_ST   = TIMER + 16'd1;
  localparam logic [ADDR_W-1:0] BUTTON     = 16'h0d00;
  localparam logic [DATA_W-1:0] DEFAULT_RD = 16'hf345;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } ack_state_e;

endpackage

// File: rtl/read_ack_fsm.sv
// One registered ack pulse per read access; held accesses do not re-trigger.
module read_ack_fsm
  import io_map_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hit,
  output logic ack
);

  ack_state_e state_q;
  ack_state_e state_d;
  logic       ack_d;
  // Previous hit; reset high so an access already present at reset release
  // is not mistaken for a fresh one.
  logic       hit_q;

  // State, ack and hit history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack     <= 1'b0;
      hit_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ack     <= ack_d;
      hit_q   <= hit;
    end
  end

  // Next state; ack is high exactly while the registered state is ACK.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit && !hit_q) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end
      end
      ACK:     state_d = hit ? WAIT : IDLE;
      WAIT:    if (!hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller: address decode, read mux, ack pulses,
// display latch and sticky pushbutton event register.
module io_ctrl
  import io_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] cpu_wdata,
  input  logic        memwt,
  output logic [15:0] cpu_rdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_we,
  input  logic [15:0] kp_keyout,
  output logic        kp_ack,
  output logic        kp_statusordata,
  input  logic [15:0] tm_timeout,
  output logic        tm_ack,
  output logic        tm_statusordata,
  output logic [15:0] seg_data,
  input  logic        pushbutton
);

  logic in_ram;
  logic kp_hit;
  logic tm_hit;
  logic btn_hit;
  logic btn_ack;
  logic sync1;
  logic sync2;
  logic sync_prev;
  logic btn_fall;
  logic btn_pend;

  // Address decode; RAM range check by offset so it holds for any base.
  always_comb begin
    in_ram          = ADDR_W'(address - BEGINMEM) <= ADDR_W'(ENDMEM - BEGINMEM);
    kp_hit          = (address == KEYPAD) && !memwt;
    tm_hit          = (address == TIMER)  && !memwt;
    btn_hit         = (address == BUTTON) && !memwt;
    mem_we          = memwt && in_ram;
    kp_statusordata = (address == KEYPAD_ST);
    tm_statusordata = (address == TIMER_ST);
    btn_fall        = sync_prev && !sync2;
  end

  // CPU read-data mux.
  always_comb begin
    cpu_rdata = DEFAULT_RD;
    if (in_ram)
      cpu_rdata = mem_rdata;
    else if ((address == KEYPAD) || (address == KEYPAD_ST))
      cpu_rdata = kp_keyout;
    else if ((address == TIMER) || (address == TIMER_ST))
      cpu_rdata = tm_timeout;
    else if (address == BUTTON)
      cpu_rdata = {(DATA_W-1)'(0), btn_pend};
  end

  // Seven-segment display latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      seg_data <= '0;
    else if (memwt && (address == SEVENSEG))
      seg_data <= cpu_wdata;
  end

  // Pushbutton synchronizer and previous-sample stage (idle level is high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= pushbutton;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // Sticky button event; a new press beats a simultaneous read-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      btn_pend <= 1'b0;
    else if (btn_fall)
      btn_pend <= 1'b1;
    else if (btn_ack)
      btn_pend <= 1'b0;
  end

  read_ack_fsm u_kp_ack  (.clk(clk), .reset(reset), .hit(kp_hit),  .ack(kp_ack));
  read_ack_fsm u_tm_ack  (.clk(clk), .reset(reset), .hit(tm_hit),  .ack(tm_ack));
  read_ack_fsm u_btn_ack (.clk(clk), .reset(reset), .hit(btn_hit), .ack(btn_ack));

endmodule

// File: tb/tb_io_ctrl.sv
// Scoreboard bench for io_ctrl: driver pushes per-cycle expectations,
// monitor pops and compares on the falling edge.
module tb_io_ctrl;

  localparam logic [15:0] MEMV = 16'h1234;
  localparam logic [15:0] KPV  = 16'h0007;
  localparam logic [15:0] TMV  = 16'h00a5;
  localparam logic [15:0] DEFV = 16'hf345;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [15:0] cpu_wdata;
  logic        memwt;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic [15:0] kp_keyout;
  logic        kp_ack;
  logic        kp_statusordata;
  logic [15:0] tm_timeout;
  logic        tm_ack;
  logic        tm_statusordata;
  logic [15:0] seg_data;
  logic        pushbutton;

  typedef struct {
    string       name;
    logic [15:0] rd;
    logic        kp;
    logic        tm;
    logic        ksod;
    logic        tsod;
    logic        we;
    logic [15:0] seg;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  io_ctrl dut (
    .clk(clk), .reset(reset), .address(address), .cpu_wdata(cpu_wdata),
    .memwt(memwt), .cpu_rdata(cpu_rdata), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .kp_keyout(kp_keyout), .kp_ack(kp_ack), .kp_statusordata(kp_statusordata),
    .tm_timeout(tm_timeout), .tm_ack(tm_ack), .tm_statusordata(tm_statusordata),
    .seg_data(seg_data), .pushbutton(pushbutton)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string nm, input logic [15:0] rd, input logic kp,
                          input logic tm, input logic ksod, input logic tsod,
                          input logic we, input logic [15:0] seg);
    exp_t e;
    e.name = nm; e.rd = rd; e.kp = kp; e.tm = tm;
    e.ksod = ksod; e.tsod = tsod; e.we = we; e.seg = seg;
    q.push_back(e);
  endtask

  // One cycle: drive inputs just after the rising edge and queue the expectation.
  task automatic step(input string nm, input logic [15:0] a, input logic wt,
                      input logic [15:0] wd, input logic pb, input logic [15:0] rd,
                      input logic kp, input logic tm, input logic ksod, input logic tsod,
                      input logic we, input logic [15:0] seg);
    @(posedge clk);
    #1;
    address    = a;
    memwt      = wt;
    cpu_wdata  = wd;
    pushbutton = pb;
    push_exp(nm, rd, kp, tm, ksod, tsod, we, seg);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always begin : monitor
    exp_t e;
    logic [36:0] act;
    logic [36:0] expv;
    @(negedge clk or chk_ev);
    while (q.size() > 0) begin
      e    = q.pop_front();
      act  = {cpu_rdata, kp_ack, tm_ack, kp_statusordata, tm_statusordata, mem_we, seg_data};
      expv = {e.rd, e.kp, e.tm, e.ksod, e.tsod, e.we, e.seg};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s: got rd=%h kp_ack=%b tm_ack=%b kp_sod=%b tm_sod=%b we=%b seg=%h, expected rd=%h kp_ack=%b tm_ack=%b kp_sod=%b tm_sod=%b we=%b seg=%h",
                 e.name, cpu_rdata, kp_ack, tm_ack, kp_statusordata, tm_statusordata,
                 mem_we, seg_data, e.rd, e.kp, e.tm, e.ksod, e.tsod, e.we, e.seg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    address    = 16'h0005;
    cpu_wdata  = 16'h0000;
    memwt      = 1'b0;
    pushbutton = 1'b1;
    mem_rdata  = MEMV;
    kp_keyout  = KPV;
    tm_timeout = TMV;

    #3;
    push_exp("reset_state", MEMV, 0, 0, 0, 0, 0, 16'h0000);
    -> chk_ev;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    //   name         addr      wt wdata     pb rd    kp tm ks ts we seg
    step("ram_rd",    16'h0005, 0, 16'h0000, 1, MEMV, 0, 0, 0, 0, 0, 16'h0000);
    step("ram_wr",    16'h0005, 1, 16'h5555, 1, MEMV, 0, 0, 0, 0, 1, 16'h0000);
    step("kp_c1",     16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'h0000);
    step("kp_c2",     16'h0900, 0, 16'h0000, 1, KPV,  1, 0, 0, 0, 0, 16'h0000);
    step("kp_c3",     16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'h0000);
    step("kp_c4",     16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'h0000);
    step("kp_leave",  16'h0005, 0, 16'h0000, 1, MEMV, 0, 0, 0, 0, 0, 16'h0000);
    step("kp_re1",    16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'h0000);
    step("kp_re2",    16'h0900, 0, 16'h0000, 1, KPV,  1, 0, 0, 0, 0, 16'h0000);
    step("tm_st1",    16'h0c01, 0, 16'h0000, 1, TMV,  0, 0, 0, 1, 0, 16'h0000);
    step("tm_st2",    16'h0c01, 0, 16'h0000, 1, TMV,  0, 0, 0, 1, 0, 16'h0000);
    step("tm_st3",    16'h0c01, 0, 16'h0000, 1, TMV,  0, 0, 0, 1, 0, 16'h0000);
    step("tm_d1",     16'h0c00, 0, 16'h0000, 1, TMV,  0, 0, 0, 0, 0, 16'h0000);
    step("tm_d2",     16'h0c00, 0, 16'h0000, 1, TMV,  0, 1, 0, 0, 0, 16'h0000);
    step("seg_wr",    16'h0b00, 1, 16'hbeef, 1, DEFV, 0, 0, 0, 0, 0, 16'h0000);
    step("kp_wr1",    16'h0900, 1, 16'h1111, 1, KPV,  0, 0, 0, 0, 0, 16'hbeef);
    step("kp_wr2",    16'h0900, 1, 16'h1111, 1, KPV,  0, 0, 0, 0, 0, 16'hbeef);
    step("pb_fall",   16'h0005, 0, 16'h0000, 0, MEMV, 0, 0, 0, 0, 0, 16'hbeef);
    step("pb_s1",     16'h0005, 0, 16'h0000, 0, MEMV, 0, 0, 0, 0, 0, 16'hbeef);
    step("pb_s2",     16'h0005, 0, 16'h0000, 0, MEMV, 0, 0, 0, 0, 0, 16'hbeef);
    step("btn_rd1",   16'h0d00, 0, 16'h0000, 0, 16'h0001, 0, 0, 0, 0, 0, 16'hbeef);
    step("btn_rd2",   16'h0d00, 0, 16'h0000, 0, 16'h0001, 0, 0, 0, 0, 0, 16'hbeef);
    step("btn_leave", 16'h0005, 0, 16'h0000, 0, MEMV, 0, 0, 0, 0, 0, 16'hbeef);
    step("btn_clr1",  16'h0d00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'hbeef);
    step("btn_clr2",  16'h0d00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'hbeef);
    step("pb_rise",   16'h0005, 0, 16'h0000, 1, MEMV, 0, 0, 0, 0, 0, 16'hbeef);
    step("pb_fall2",  16'h0005, 0, 16'h0000, 0, MEMV, 0, 0, 0, 0, 0, 16'hbeef);
    step("btn_sw1",   16'h0d00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'hbeef);
    step("btn_sw2",   16'h0d00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'hbeef);
    step("btn_sw3",   16'h0d00, 0, 16'h0000, 0, 16'h0001, 0, 0, 0, 0, 0, 16'hbeef);
    step("btn_sw4",   16'h0d00, 0, 16'h0000, 0, 16'h0001, 0, 0, 0, 0, 0, 16'hbeef);
    step("idle",      16'h0005, 0, 16'h0000, 1, MEMV, 0, 0, 0, 0, 0, 16'hbeef);
    step("kp_a1",     16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'hbeef);
    step("kp_a2",     16'h0900, 0, 16'h0000, 1, KPV,  1, 0, 0, 0, 0, 16'hbeef);

    // Asynchronous reset in the middle of the ack cycle.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    push_exp("rst_async", KPV, 0, 0, 0, 0, 0, 16'h0000);
    -> chk_ev;
    @(posedge clk);
    #1;
    reset = 1'b0;

    step("rst_hold1", 16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'h0000);
    step("rst_hold2", 16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'h0000);
    step("rst_hold3", 16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'h0000);
    step("rst_leave", 16'h0005, 0, 16'h0000, 1, MEMV, 0, 0, 0, 0, 0, 16'h0000);
    step("kp_f1",     16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'h0000);
    step("kp_f2",     16'h0900, 0, 16'h0000, 1, KPV,  1, 0, 0, 0, 0, 16'h0000);
    step("kp_f3",     16'h0900, 0, 16'h0000, 1, KPV,  0, 0, 0, 0, 0, 16'h0000);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
